// File: rtl/fetch_issue_ctrl.sv
// Fetch-to-issue controller: one-entry hold register, registered issue slot,
// register scoreboard with hazard stall, HALT freeze and flush.
module fetch_issue_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [4:0]  f_opcode,
  input  logic [3:0]  f_s1,
  input  logic [3:0]  f_s2,
  input  logic [3:0]  f_dest,
  input  logic [31:0] f_ime,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [4:0]  iss_opcode,
  output logic [3:0]  iss_s1,
  output logic [3:0]  iss_s2,
  output logic [3:0]  iss_dest,
  output logic [31:0] iss_ime,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dest,
  input  logic        flush,
  output logic [15:0] pending,
  output logic        halted,
  output logic [7:0]  stall_cnt
);

  localparam logic [4:0] OpNop   = 5'b00000;
  localparam logic [4:0] OpHalt  = 5'b11111;
  localparam logic [4:0] OpStore = 5'b01111;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic        hold_v_q, hold_v_d;
  logic [4:0]  hold_opcode_q, hold_opcode_d;
  logic [3:0]  hold_s1_q, hold_s1_d, hold_s2_q, hold_s2_d, hold_dest_q, hold_dest_d;
  logic [31:0] hold_ime_q, hold_ime_d;
  logic        iss_valid_q, iss_valid_d;
  logic [4:0]  iss_opcode_q, iss_opcode_d;
  logic [3:0]  iss_s1_q, iss_s1_d, iss_s2_q, iss_s2_d, iss_dest_q, iss_dest_d;
  logic [31:0] iss_ime_q, iss_ime_d;
  logic [15:0] pending_q, pending_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;

  logic rd_s1, rd_s2, wr_dest, hazard, transfer, accept, running;

  // Operand usage of the instruction sitting in the hold register
  always_comb begin
    rd_s1   = 1'b0;
    rd_s2   = 1'b0;
    wr_dest = 1'b0;
    if (hold_opcode_q == OpNop || hold_opcode_q == OpHalt) begin
      rd_s1 = 1'b0;
    end else if (hold_opcode_q == OpStore) begin
      rd_s1 = 1'b1;
      rd_s2 = 1'b1;
    end else if (hold_opcode_q[4]) begin
      rd_s1   = 1'b1;
      wr_dest = 1'b1;
    end else begin
      rd_s1   = 1'b1;
      rd_s2   = 1'b1;
      wr_dest = 1'b1;
    end
  end

  // pending_q[0] is held at zero, so r0 can never raise a hazard
  assign hazard = hold_v_q && ((rd_s1 && pending_q[hold_s1_q]) ||
                               (rd_s2 && pending_q[hold_s2_q]) ||
                               (wr_dest && pending_q[hold_dest_q]));
  assign running  = (state_q == StRun);
  // flush overrides any transfer in the same cycle
  assign transfer = hold_v_q && !hazard && (!iss_valid_q || iss_ready) && running && !flush;
  assign f_ready  = running && !flush && (!hold_v_q || transfer);
  assign accept   = f_valid && f_ready;

  always_comb begin
    state_d       = state_q;
    hold_v_d      = hold_v_q;
    hold_opcode_d = hold_opcode_q;
    hold_s1_d     = hold_s1_q;
    hold_s2_d     = hold_s2_q;
    hold_dest_d   = hold_dest_q;
    hold_ime_d    = hold_ime_q;
    iss_valid_d   = iss_valid_q;
    iss_opcode_d  = iss_opcode_q;
    iss_s1_d      = iss_s1_q;
    iss_s2_d      = iss_s2_q;
    iss_dest_d    = iss_dest_q;
    iss_ime_d     = iss_ime_q;
    pending_d     = pending_q;
    stall_cnt_d   = stall_cnt_q;

    if (flush) begin
      hold_v_d = 1'b0;
    end else if (accept) begin
      hold_v_d      = 1'b1;
      hold_opcode_d = f_opcode;
      hold_s1_d     = f_s1;
      hold_s2_d     = f_s2;
      hold_dest_d   = f_dest;
      hold_ime_d    = f_ime;
    end else if (transfer) begin
      hold_v_d = 1'b0;
    end

    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (transfer) begin
      iss_valid_d  = 1'b1;
      iss_opcode_d = hold_opcode_q;
      iss_s1_d     = hold_s1_q;
      iss_s2_d     = hold_s2_q;
      iss_dest_d   = hold_dest_q;
      iss_ime_d    = hold_ime_q;
    end else if (iss_ready) begin
      iss_valid_d = 1'b0;
    end

    // Clear first so a same-cycle set of the same register wins
    if (wb_valid) pending_d[wb_dest] = 1'b0;
    if (transfer && wr_dest) pending_d[hold_dest_q] = 1'b1;
    pending_d[0] = 1'b0;

    if (hold_v_q && hazard && running && !flush && stall_cnt_q != 8'hFF) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end

    if (transfer && hold_opcode_q == OpHalt) state_d = StHalt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StRun;
      hold_v_q      <= 1'b0;
      hold_opcode_q <= '0;
      hold_s1_q     <= '0;
      hold_s2_q     <= '0;
      hold_dest_q   <= '0;
      hold_ime_q    <= '0;
      iss_valid_q   <= 1'b0;
      iss_opcode_q  <= '0;
      iss_s1_q      <= '0;
      iss_s2_q      <= '0;
      iss_dest_q    <= '0;
      iss_ime_q     <= '0;
      pending_q     <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_v_q      <= hold_v_d;
      hold_opcode_q <= hold_opcode_d;
      hold_s1_q     <= hold_s1_d;
      hold_s2_q     <= hold_s2_d;
      hold_dest_q   <= hold_dest_d;
      hold_ime_q    <= hold_ime_d;
      iss_valid_q   <= iss_valid_d;
      iss_opcode_q  <= iss_opcode_d;
      iss_s1_q      <= iss_s1_d;
      iss_s2_q      <= iss_s2_d;
      iss_dest_q    <= iss_dest_d;
      iss_ime_q     <= iss_ime_d;
      pending_q     <= pending_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_opcode_q;
  assign iss_s1     = iss_s1_q;
  assign iss_s2     = iss_s2_q;
  assign iss_dest   = iss_dest_q;
  assign iss_ime    = iss_ime_q;
  assign pending    = pending_q;
  assign halted     = (state_q == StHalt);
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl: accepted instructions are queued and
// compared in order against what the issue port hands to decode.
module tb_fetch_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_valid, f_ready;
  logic [4:0]  f_opcode;
  logic [3:0]  f_s1, f_s2, f_dest;
  logic [31:0] f_ime;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_opcode;
  logic [3:0]  iss_s1, iss_s2, iss_dest;
  logic [31:0] iss_ime;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        flush;
  logic [15:0] pending;
  logic        halted;
  logic [7:0]  stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [48:0] sb_q[$];

  fetch_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .f_valid(f_valid), .f_ready(f_ready),
    .f_opcode(f_opcode), .f_s1(f_s1), .f_s2(f_s2), .f_dest(f_dest), .f_ime(f_ime),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_s1(iss_s1), .iss_s2(iss_s2), .iss_dest(iss_dest),
    .iss_ime(iss_ime),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .pending(pending), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] dest, input logic [31:0] ime);
    f_valid  = 1'b1;
    f_opcode = op;
    f_s1     = s1;
    f_s2     = s2;
    f_dest   = dest;
    f_ime    = ime;
  endtask

  task automatic idle();
    f_valid = 1'b0;
  endtask

  // Sample away from the edge, update the scoreboard, then advance one cycle
  task automatic step();
    logic [48:0] exp;
    #1;
    if (reset_n) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (iss_valid && iss_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_issue", 64'(iss_opcode), 64'hFFFF);
          end else begin
            exp = sb_q.pop_front();
            check("issue", 64'({iss_opcode, iss_s1, iss_s2, iss_dest, iss_ime}), 64'(exp));
          end
        end
        if (f_valid && f_ready) sb_q.push_back({f_opcode, f_s1, f_s2, f_dest, f_ime});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; f_valid = 1'b0; f_opcode = '0; f_s1 = '0; f_s2 = '0; f_dest = '0;
    f_ime = '0; iss_ready = 1'b1; wb_valid = 1'b0; wb_dest = '0; flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_iss_valid", 64'(iss_valid), 0);
    check("rst_pending", 64'(pending), 0);
    check("rst_stall", 64'(stall_cnt), 0);
    check("rst_halted", 64'(halted), 0);
    check("rst_iss_fields", 64'({iss_opcode, iss_s1, iss_s2, iss_dest, iss_ime}), 0);
    reset_n = 1'b1;
    #1;
    check("rst_f_ready", 64'(f_ready), 1);

    // RAW hazard on r3, released by writeback
    drive(5'b00001, 4'd1, 4'd2, 4'd3, 32'h11);
    step();
    drive(5'b00010, 4'd3, 4'd4, 4'd5, 32'h22);
    #1;
    check("raw_flow_through_ready", 64'(f_ready), 1);
    step();
    idle();
    check("raw_first_issued", 64'(iss_valid), 1);
    check("raw_pending_r3", 64'(pending), 64'h0008);
    for (int i = 0; i < 5; i++) step();
    check("raw_stall5", 64'(stall_cnt), 5);
    check("raw_second_held", 64'(iss_valid), 0);
    check("raw_f_ready_blocked", 64'(f_ready), 0);
    wb_valid = 1'b1; wb_dest = 4'd3;
    step();
    wb_valid = 1'b0;
    check("raw_wb_cleared", 64'(pending), 0);
    check("raw_no_bypass", 64'(iss_valid), 0);
    check("raw_stall6", 64'(stall_cnt), 6);
    step();
    check("raw_second_issued", 64'(iss_valid), 1);
    check("raw_pending_r5", 64'(pending), 64'h0020);
    check("raw_stall_frozen", 64'(stall_cnt), 6);
    step();
    wb_valid = 1'b1; wb_dest = 4'd5;
    step();
    wb_valid = 1'b0;
    check("raw_r5_cleared", 64'(pending), 0);

    // r0 never pends nor stalls
    drive(5'b10001, 4'd0, 4'd0, 4'd0, 32'h33);
    step();
    drive(5'b00011, 4'd0, 4'd0, 4'd6, 32'h44);
    step();
    idle();
    check("r0_no_pending", 64'(pending), 0);
    step();
    check("r0_second_issued", 64'(iss_valid), 1);
    check("r0_pending_r6", 64'(pending), 64'h0040);
    check("r0_no_stall", 64'(stall_cnt), 6);
    step();
    wb_valid = 1'b1; wb_dest = 4'd6;
    step();
    wb_valid = 1'b0;

    // Backpressure from decode
    drive(5'b00100, 4'd0, 4'd0, 4'd8, 32'hAAAA);
    step();
    drive(5'b10010, 4'd0, 4'd0, 4'd9, 32'hBBBB);
    iss_ready = 1'b0;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_f_ready", 64'(f_ready), 0);
      check("bp_iss_stable", 64'({iss_valid, iss_dest, iss_ime}), 64'({1'b1, 4'd8, 32'hAAAA}));
      step();
    end
    iss_ready = 1'b1;
    step();
    check("bp_second_issued", 64'({iss_valid, iss_dest}), 64'({1'b1, 4'd9}));
    step();
    check("bp_drained", 64'(iss_valid), 0);
    check("bp_no_stall", 64'(stall_cnt), 6);
    wb_valid = 1'b1; wb_dest = 4'd8;
    step();
    wb_dest = 4'd9;
    step();
    wb_valid = 1'b0;
    check("bp_pending_clear", 64'(pending), 0);

    // Same-cycle set and clear of r7
    drive(5'b10100, 4'd0, 4'd0, 4'd7, 32'h77);
    step();
    idle();
    wb_valid = 1'b1; wb_dest = 4'd7;
    step();
    wb_valid = 1'b0;
    check("setclr_r7", 64'(pending), 64'h0080);
    step();
    wb_valid = 1'b1; wb_dest = 4'd7;
    step();
    wb_valid = 1'b0;
    check("setclr_r7_cleared", 64'(pending), 0);

    // Long stall saturates, then flush
    iss_ready = 1'b0;
    drive(5'b10011, 4'd0, 4'd0, 4'd10, 32'hA0);
    step();
    drive(5'b00101, 4'd10, 4'd0, 4'd11, 32'hB0);
    step();
    idle();
    for (int i = 0; i < 300; i++) step();
    check("sat_stall", 64'(stall_cnt), 255);
    check("sat_pending", 64'(pending), 64'h0400);
    check("sat_iss_valid", 64'(iss_valid), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("flush_iss_valid", 64'(iss_valid), 0);
    check("flush_pending_kept", 64'(pending), 64'h0400);
    check("flush_stall_kept", 64'(stall_cnt), 255);
    check("flush_hold_empty", 64'(f_ready), 1);
    iss_ready = 1'b1;
    wb_valid = 1'b1; wb_dest = 4'd10;
    step();
    wb_valid = 1'b0;
    check("flush_wb_clear", 64'(pending), 0);

    // HALT freezes the controller until reset
    drive(5'b10101, 4'd0, 4'd0, 4'd13, 32'hD0);
    step();
    drive(5'b11111, 4'd0, 4'd0, 4'd0, 32'h0);
    step();
    drive(5'b00110, 4'd13, 4'd0, 4'd12, 32'hC0);
    step();
    check("halt_halted", 64'(halted), 1);
    check("halt_on_iss", 64'({iss_valid, iss_opcode}), 64'({1'b1, 5'b11111}));
    check("halt_pending_r13", 64'(pending), 64'h2000);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halt_f_ready", 64'(f_ready), 0);
      step();
    end
    check("halt_accepted", 64'(iss_valid), 0);
    wb_valid = 1'b1; wb_dest = 4'd13;
    step();
    wb_valid = 1'b0;
    check("halt_wb_clears", 64'(pending), 0);
    check("halt_still_halted", 64'(halted), 1);

    // Asynchronous reset mid-cycle discards everything
    drive(5'b10110, 4'd0, 4'd0, 4'd14, 32'hE0);
    step();
    reset_n = 1'b0;
    #1;
    check("arst_halted", 64'(halted), 0);
    check("arst_iss", 64'({iss_valid, iss_opcode, iss_dest, iss_ime}), 0);
    check("arst_pending", 64'(pending), 0);
    check("arst_stall", 64'(stall_cnt), 0);
    sb_q.delete();
    idle();
    step();
    reset_n = 1'b1;
    #1;
    check("arst_f_ready", 64'(f_ready), 1);
    check("arst_no_ghost_issue", 64'(iss_valid), 0);
    drive(5'b10111, 4'd0, 4'd0, 4'd1, 32'h1234);
    step();
    idle();
    step();
    check("post_rst_issue", 64'({iss_valid, iss_dest, iss_ime}), 64'({1'b1, 4'd1, 32'h1234}));
    step();
    check("sb_drained", 64'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
